// File: rtl/sync_level_event_capture.sv
// Glitch-filtered level capture with edge pulses, wrapping event count and req/ack pending queue; level_o/rise_o/fall_o land FILT_CYCLES-1 edges after the first new sample, evt_req one cycle after the pulse.
// Backpressure: evt_ack drains one event per cycle; a full pending counter drops events and sets sticky evt_ovf. Define SYNC_EVT_FALL_EN to count fall edges as events too.
module sync_level_event_capture #(
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              b_clk,
    input  logic              b_rst_n,
    input  logic              sync_data,
    input  logic              clr_cnt,
    input  logic              evt_ack,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              evt_req,
    output logic [PEND_W-1:0] evt_pend,
    output logic              evt_ovf
);

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [7:0] FILT_LAST   = 8'(FILT_CYCLES);
    localparam bit         FILT_BYPASS = (FILT_CYCLES == 1);

    state_t              r_state;
    logic [7:0]          r_filt_cnt;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic [CNT_W-1:0]    r_evt_cnt;
    logic [PEND_W-1:0]   r_evt_pend;
    logic                r_evt_ovf;

    logic [7:0]          w_filt_next;
    logic                w_filt_done;
    logic                w_evt;
    logic                w_ack;
    logic                w_pend_full;

    assign w_filt_next = r_filt_cnt + 8'd1;
    assign w_filt_done = (w_filt_next >= FILT_LAST);

    // Level filter FSM; pulses are registered alongside the level they announce.
    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_state    <= LO;
            r_filt_cnt <= 8'd0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LO: begin
                    if (sync_data) begin
                        if (FILT_BYPASS) begin
                            r_state <= HI;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state    <= CHK_HI;
                            r_filt_cnt <= 8'd1;
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync_data) begin
                        r_state    <= LO;
                        r_filt_cnt <= 8'd0;
                    end else if (w_filt_done) begin
                        r_state    <= HI;
                        r_filt_cnt <= 8'd0;
                        r_level    <= 1'b1;
                        r_rise     <= 1'b1;
                    end else begin
                        r_filt_cnt <= w_filt_next;
                    end
                end
                HI: begin
                    if (!sync_data) begin
                        if (FILT_BYPASS) begin
                            r_state <= LO;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state    <= CHK_LO;
                            r_filt_cnt <= 8'd1;
                        end
                    end
                end
                CHK_LO: begin
                    if (sync_data) begin
                        r_state    <= HI;
                        r_filt_cnt <= 8'd0;
                    end else if (w_filt_done) begin
                        r_state    <= LO;
                        r_filt_cnt <= 8'd0;
                        r_level    <= 1'b0;
                        r_fall     <= 1'b1;
                    end else begin
                        r_filt_cnt <= w_filt_next;
                    end
                end
                default: begin
                    r_state    <= LO;
                    r_filt_cnt <= 8'd0;
                    r_level    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYNC_EVT_FALL_EN
    assign w_evt = r_rise | r_fall;
`else
    assign w_evt = r_rise;
`endif

    assign w_ack       = evt_ack && evt_req;
    assign w_pend_full = &r_evt_pend;

    // Events are taken from the registered pulses, so counters move one edge after the pulse.
    always_ff @(posedge b_clk or negedge b_rst_n) begin
        if (!b_rst_n) begin
            r_evt_cnt  <= '0;
            r_evt_pend <= '0;
            r_evt_ovf  <= 1'b0;
        end else begin
            if (clr_cnt) begin
                r_evt_cnt <= w_evt ? CNT_W'(1) : '0;
            end else if (w_evt) begin
                r_evt_cnt <= r_evt_cnt + CNT_W'(1);
            end

            if (w_evt && !w_ack) begin
                if (!w_pend_full) begin
                    r_evt_pend <= r_evt_pend + PEND_W'(1);
                end
            end else if (!w_evt && w_ack) begin
                r_evt_pend <= r_evt_pend - PEND_W'(1);
            end

            if (clr_cnt) begin
                r_evt_ovf <= 1'b0;
            end else if (w_evt && !w_ack && w_pend_full) begin
                r_evt_ovf <= 1'b1;
            end
        end
    end

    assign level_o  = r_level;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign evt_cnt  = r_evt_cnt;
    assign evt_pend = r_evt_pend;
    assign evt_ovf  = r_evt_ovf;
    assign evt_req  = |r_evt_pend;

endmodule
